// File: rtl/ceespu_hazard_unit_if.sv
// ceespu_hazard_unit_if: decode/execute hazard signalling bundle
interface ceespu_hazard_unit_if #(
   parameter int REG_W   = 5,
   parameter int NUM_SRC = 3,
   parameter int SEL_W   = 2
);
   logic                     I_dec_valid;
   logic                     I_dec_we;
   logic                     I_dec_isLoad;
   logic [REG_W-1:0]         I_dec_regD;
   logic [NUM_SRC*REG_W-1:0] I_dec_src;
   logic [NUM_SRC-1:0]       I_dec_srcUsed;
   logic                     I_ex_busy;
   logic                     I_dmem_busy;
   logic                     I_flush;
   logic                     O_stall;
   logic                     O_bubble;
   logic [NUM_SRC*SEL_W-1:0] O_fwd_sel;
   logic [31:0]              O_bubble_count;
   logic [31:0]              O_freeze_count;
   modport master (
      output I_dec_valid, I_dec_we, I_dec_isLoad, I_dec_regD, I_dec_src, I_dec_srcUsed,
             I_ex_busy, I_dmem_busy, I_flush,
      input  O_stall, O_bubble, O_fwd_sel, O_bubble_count, O_freeze_count
   );
   modport slave (
      input  I_dec_valid, I_dec_we, I_dec_isLoad, I_dec_regD, I_dec_src, I_dec_srcUsed,
             I_ex_busy, I_dmem_busy, I_flush,
      output O_stall, O_bubble, O_fwd_sel, O_bubble_count, O_freeze_count
   );
endinterface

// File: rtl/ceespu_hazard_unit.sv
// ceespu_hazard_unit: scoreboard-based forwarding select and load-use/freeze stall control
module ceespu_hazard_unit #(
   parameter int REG_W      = 5,
   parameter int NUM_SRC    = 3,
   parameter int NUM_STAGES = 2,
   parameter int LOAD_LAT   = 1,
   parameter int ZERO_REG   = 1,
   parameter int SEL_W      = 2
) (
   input logic I_clk,
   input logic I_rst,
   ceespu_hazard_unit_if.slave bus
);
   logic [NUM_STAGES:1]      sb_valid, sb_we, sb_load;
   logic [REG_W-1:0]         sb_reg [1:NUM_STAGES];
   logic [NUM_SRC*SEL_W-1:0] sel, fwd_sel;
   logic [NUM_SRC-1:0]       src_haz;
   logic [31:0]              bubble_count, freeze_count;
   logic                     hazard, busy, issue;
   // per source: nearest in-flight producer (scan far to near so the nearest overwrites) and its load-use status
   always_comb begin
      sel = '0;
      src_haz = '0;
      for (int s = 0; s < NUM_SRC; s++)
         for (int d = NUM_STAGES; d >= 1; d--)
            if (bus.I_dec_srcUsed[s] && sb_valid[d] && sb_we[d] &&
                sb_reg[d] == bus.I_dec_src[s*REG_W +: REG_W] &&
                !(ZERO_REG != 0 && bus.I_dec_src[s*REG_W +: REG_W] == '0)) begin
               sel[s*SEL_W +: SEL_W] = SEL_W'(d);
               src_haz[s] = sb_load[d] && d <= LOAD_LAT;
            end
   end
   assign hazard = bus.I_dec_valid && |src_haz;
   assign busy   = bus.I_ex_busy || bus.I_dmem_busy;
   assign issue  = !bus.I_flush && !busy && !hazard;
   assign bus.O_stall        = !I_rst && !bus.I_flush && (hazard || busy);
   assign bus.O_bubble       = !I_rst && !bus.I_flush && hazard && !busy;
   assign bus.O_fwd_sel      = fwd_sel;
   assign bus.O_bubble_count = bubble_count;
   assign bus.O_freeze_count = freeze_count;
   // scoreboard advances on issue, bubble and flush; a busy freeze holds everything but the freeze counter
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         sb_valid     <= '0;
         sb_we        <= '0;
         sb_load      <= '0;
         fwd_sel      <= '0;
         bubble_count <= '0;
         freeze_count <= '0;
         for (int d = 1; d <= NUM_STAGES; d++) sb_reg[d] <= '0;
      end else begin
         if (bus.I_flush || !busy) begin
            for (int d = NUM_STAGES; d >= 2; d--) begin
               sb_valid[d] <= sb_valid[d-1];
               sb_we[d]    <= sb_we[d-1];
               sb_load[d]  <= sb_load[d-1];
               sb_reg[d]   <= sb_reg[d-1];
            end
            sb_valid[1] <= issue && bus.I_dec_valid;
            sb_we[1]    <= bus.I_dec_we;
            sb_load[1]  <= bus.I_dec_isLoad;
            sb_reg[1]   <= bus.I_dec_regD;
            fwd_sel     <= issue ? sel : '0;
         end
         if (!bus.I_flush && busy && ~&freeze_count) freeze_count <= freeze_count + 32'd1;
         if (!bus.I_flush && !busy && hazard && ~&bubble_count) bubble_count <= bubble_count + 32'd1;
      end
   end
endmodule

// File: tb/tb_ceespu_hazard_unit.sv
// tb_ceespu_hazard_unit: directed vector table plus hand sequences for freeze, flush, reset and parameter variants
module tb_ceespu_hazard_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;

   ceespu_hazard_unit_if b0 ();
   ceespu_hazard_unit_if b1 ();
   ceespu_hazard_unit_if b2 ();
   ceespu_hazard_unit u0 (.I_clk(clk), .I_rst(rst), .bus(b0.slave));
   ceespu_hazard_unit #(.NUM_STAGES(3), .LOAD_LAT(2)) u1 (.I_clk(clk), .I_rst(rst), .bus(b1.slave));
   ceespu_hazard_unit #(.ZERO_REG(0)) u2 (.I_clk(clk), .I_rst(rst), .bus(b2.slave));

   typedef struct {
      logic        v, we, ld;
      logic [4:0]  rd;
      logic [14:0] src;
      logic [2:0]  used;
      logic        st, bb, cs;
      logic [5:0]  sel;
   } vec_t;
   vec_t tbl [14];

   function automatic logic [14:0] pk(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
      return {c, b, a};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // drive one decode slot on u0 at the falling edge, check the combinational response, then clock it in
   task automatic step0(input string n, input logic v, input logic we, input logic ld, input logic [4:0] rd,
                        input logic [14:0] src, input logic [2:0] used, input logic [1:0] bsy, input logic fl,
                        input logic st, input logic bb);
      @(negedge clk);
      b0.I_dec_valid = v;
      b0.I_dec_we = we;
      b0.I_dec_isLoad = ld;
      b0.I_dec_regD = rd;
      b0.I_dec_src = src;
      b0.I_dec_srcUsed = used;
      b0.I_ex_busy = bsy[0];
      b0.I_dmem_busy = bsy[1];
      b0.I_flush = fl;
      #1;
      check({n, " stall"}, b0.O_stall, st);
      check({n, " bubble"}, b0.O_bubble, bb);
      @(posedge clk);
      #1;
   endtask

   initial begin
      //                v  we ld rd  src            used  st bb cs sel
      tbl[0]  = '{1, 1, 0, 3,  pk(0, 0, 0),   3'b000, 0, 0, 1, 6'h00};
      tbl[1]  = '{1, 1, 0, 4,  pk(3, 5, 0),   3'b011, 0, 0, 1, 6'h01};
      tbl[2]  = '{1, 1, 0, 7,  pk(0, 0, 0),   3'b000, 0, 0, 1, 6'h00};
      tbl[3]  = '{1, 1, 0, 8,  pk(9, 0, 0),   3'b001, 0, 0, 1, 6'h00};
      tbl[4]  = '{1, 0, 0, 0,  pk(0, 0, 7),   3'b100, 0, 0, 1, 6'h20};
      tbl[5]  = '{1, 0, 0, 0,  pk(7, 0, 0),   3'b001, 0, 0, 1, 6'h00};
      tbl[6]  = '{1, 1, 1, 2,  pk(0, 0, 0),   3'b000, 0, 0, 1, 6'h00};
      tbl[7]  = '{1, 1, 0, 10, pk(2, 0, 0),   3'b001, 1, 1, 1, 6'h00};
      tbl[8]  = '{1, 1, 0, 10, pk(2, 0, 0),   3'b001, 0, 0, 1, 6'h02};
      tbl[9]  = '{1, 1, 0, 0,  pk(0, 0, 0),   3'b000, 0, 0, 1, 6'h00};
      tbl[10] = '{1, 1, 0, 11, pk(10, 0, 0),  3'b011, 0, 0, 1, 6'h02};
      tbl[11] = '{1, 1, 1, 5,  pk(0, 0, 0),   3'b000, 0, 0, 1, 6'h00};
      tbl[12] = '{0, 1, 0, 1,  pk(5, 0, 0),   3'b001, 0, 0, 0, 6'h00};
      tbl[13] = '{1, 1, 0, 12, pk(5, 0, 0),   3'b001, 0, 0, 1, 6'h02};

      b0.I_dec_valid = 0; b0.I_dec_we = 0; b0.I_dec_isLoad = 0; b0.I_dec_regD = 0;
      b0.I_dec_src = 0; b0.I_dec_srcUsed = 0; b0.I_ex_busy = 1; b0.I_dmem_busy = 0; b0.I_flush = 0;
      b1.I_dec_valid = 0; b1.I_dec_we = 0; b1.I_dec_isLoad = 0; b1.I_dec_regD = 0;
      b1.I_dec_src = 0; b1.I_dec_srcUsed = 0; b1.I_ex_busy = 0; b1.I_dmem_busy = 0; b1.I_flush = 0;
      b2.I_dec_valid = 0; b2.I_dec_we = 0; b2.I_dec_isLoad = 0; b2.I_dec_regD = 0;
      b2.I_dec_src = 0; b2.I_dec_srcUsed = 0; b2.I_ex_busy = 0; b2.I_dmem_busy = 0; b2.I_flush = 0;

      repeat (2) @(posedge clk);
      #1;
      check("reset stall", b0.O_stall, 0);
      check("reset bubble", b0.O_bubble, 0);
      check("reset sel", b0.O_fwd_sel, 0);
      check("reset bubble_count", b0.O_bubble_count, 0);
      check("reset freeze_count", b0.O_freeze_count, 0);
      @(negedge clk);
      b0.I_ex_busy = 0;
      rst = 0;

      for (int i = 0; i < 14; i++) begin
         step0($sformatf("vec%0d", i), tbl[i].v, tbl[i].we, tbl[i].ld, tbl[i].rd, tbl[i].src,
               tbl[i].used, 2'b00, 1'b0, tbl[i].st, tbl[i].bb);
         if (tbl[i].cs) check($sformatf("vec%0d sel", i), b0.O_fwd_sel, tbl[i].sel);
      end
      check("table bubble_count", b0.O_bubble_count, 1);
      check("table freeze_count", b0.O_freeze_count, 0);

      step0("frz load", 1, 1, 1, 6, pk(12, 0, 0), 3'b001, 2'b00, 0, 0, 0);
      check("frz load sel", b0.O_fwd_sel, 6'h01);
      step0("frz0", 1, 1, 0, 13, pk(6, 0, 0), 3'b001, 2'b01, 0, 1, 0);
      check("frz0 sel", b0.O_fwd_sel, 6'h01);
      step0("frz1", 1, 1, 0, 13, pk(6, 0, 0), 3'b001, 2'b01, 0, 1, 0);
      check("frz1 sel", b0.O_fwd_sel, 6'h01);
      step0("frz2", 1, 1, 0, 13, pk(6, 0, 0), 3'b001, 2'b10, 0, 1, 0);
      check("frz2 sel", b0.O_fwd_sel, 6'h01);
      check("frz freeze_count", b0.O_freeze_count, 3);
      check("frz bubble_count", b0.O_bubble_count, 1);
      step0("frz bubble", 1, 1, 0, 13, pk(6, 0, 0), 3'b001, 2'b00, 0, 1, 1);
      check("frz bubble sel", b0.O_fwd_sel, 0);
      check("frz bubble_count after", b0.O_bubble_count, 2);
      step0("frz issue", 1, 1, 0, 13, pk(6, 0, 0), 3'b001, 2'b00, 0, 0, 0);
      check("frz issue sel", b0.O_fwd_sel, 6'h02);

      step0("fl load", 1, 1, 1, 9, pk(0, 0, 0), 3'b000, 2'b00, 0, 0, 0);
      step0("fl flush", 1, 1, 0, 14, pk(9, 0, 0), 3'b001, 2'b01, 1, 0, 0);
      check("fl flush sel", b0.O_fwd_sel, 0);
      check("fl bubble_count", b0.O_bubble_count, 2);
      check("fl freeze_count", b0.O_freeze_count, 3);
      step0("fl reissue", 1, 1, 0, 14, pk(9, 0, 0), 3'b001, 2'b00, 0, 0, 0);
      check("fl reissue sel", b0.O_fwd_sel, 6'h02);
      check("fl reissue bubble_count", b0.O_bubble_count, 2);

      step0("rst frz", 1, 1, 0, 15, pk(1, 0, 0), 3'b001, 2'b01, 0, 1, 0);
      check("rst frz freeze_count", b0.O_freeze_count, 4);
      check("rst frz sel", b0.O_fwd_sel, 6'h02);
      @(negedge clk);
      rst = 1;
      #1;
      check("rst mid stall", b0.O_stall, 0);
      check("rst mid bubble", b0.O_bubble, 0);
      @(posedge clk);
      #1;
      check("rst mid bubble_count", b0.O_bubble_count, 0);
      check("rst mid freeze_count", b0.O_freeze_count, 0);
      check("rst mid sel", b0.O_fwd_sel, 0);
      @(negedge clk);
      rst = 0;
      b0.I_ex_busy = 0;

      @(negedge clk);
      b1.I_dec_valid = 1; b1.I_dec_we = 1; b1.I_dec_isLoad = 1; b1.I_dec_regD = 2;
      @(negedge clk);
      b1.I_dec_isLoad = 0; b1.I_dec_regD = 3; b1.I_dec_src = pk(2, 0, 0); b1.I_dec_srcUsed = 3'b001;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("lat2 stall%0d", k), b1.O_stall, k < 2);
         check($sformatf("lat2 bubble%0d", k), b1.O_bubble, k < 2);
         @(posedge clk);
         #1;
      end
      check("lat2 sel", b1.O_fwd_sel, 6'h03);
      check("lat2 bubble_count", b1.O_bubble_count, 2);

      @(negedge clk);
      b2.I_dec_valid = 1; b2.I_dec_we = 1; b2.I_dec_regD = 0;
      @(negedge clk);
      b2.I_dec_regD = 4; b2.I_dec_src = pk(0, 0, 0); b2.I_dec_srcUsed = 3'b010;
      @(posedge clk);
      #1;
      check("zero_reg0 sel", b2.O_fwd_sel, 6'h04);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ceespu_hazard_unit.md
Name: ceespu_hazard_unit

Overview:
- Parametrised pipeline hazard controller for the ceespu core. Replaces the hard-wired two-stage forwarding/stall logic.
- Tracks in-flight destination registers in a shift-register scoreboard of configurable depth.
- Generates registered per-source forwarding selects for any number of source operands, and inserts load-use bubbles sized to a configurable load latency.
- Sits between decode and execute and drives fetch/decode stall, the execute bubble and the forwarding muxes.

Parameters:
- REG_W, 5, register address width.
- NUM_SRC, 3, source operands per instruction (A, B, store data).
- NUM_STAGES, 2, forwardable result stages ahead of execute (1 = execute output register, 2 = writeback, ...).
- LOAD_LAT, 1, stages a load result is not yet forwardable; range 0..NUM_STAGES-1.
- ZERO_REG, 1, when 1, destination/source register 0 never matches.
- SEL_W, 2, width of one forward select; must satisfy 2^SEL_W > NUM_STAGES.

Ports:
- I_clk  in  1  clock.
- I_rst  in  1  reset.
- I_dec_valid  in  1  decode holds a real instruction.
- I_dec_we  in  1  decode instruction writes a register.
- I_dec_isLoad  in  1  decode instruction is a memory load.
- I_dec_regD  in  REG_W  decode destination.
- I_dec_src  in  NUM_SRC*REG_W  decode source registers; source s is in bits [s*REG_W +: REG_W].
- I_dec_srcUsed  in  NUM_SRC  source s is actually read.
- I_ex_busy  in  1  execute is multi-cycle busy.
- I_dmem_busy  in  1  data memory busy.
- I_flush  in  1  branch mispredict / squash of decode.
- O_stall  out  1  freeze fetch and decode.
- O_bubble  out  1  issue a nop into execute this cycle.
- O_fwd_sel  out  NUM_SRC*SEL_W  registered forward select per source; 0 = regfile, d = result of the instruction d positions ahead.
- O_bubble_count  out  32  load-use bubble cycles since reset.
- O_freeze_count  out  32  busy-freeze cycles since reset.

Behaviour:
- Reset: I_clk rising edge with I_rst=1 (synchronous, active-high). Clears all scoreboard entries, O_fwd_sel=0 and both counters. O_stall and O_bubble are 0 while I_rst=1.
- Scoreboard: entries 1..NUM_STAGES, each holding {valid, we, isLoad, regD}. Entry 1 is the instruction now in execute.
- Match rule: source s matches entry d if I_dec_srcUsed[s], entry valid & we, regD == src, and not (ZERO_REG & src == 0).
- Lowest d wins when several entries match.
- Load-use hazard: I_dec_valid and any source's lowest match is a load entry with d <= LOAD_LAT.
  - Response (combinational): O_stall=1, O_bubble=1.
- Freeze: no hazard and (I_ex_busy | I_dmem_busy).
  - Response: O_stall=1, O_bubble=0.
  - Scoreboard, O_fwd_sel and O_bubble_count hold. O_freeze_count increments.
- Hazard and busy together: freeze semantics apply and the hazard is re-evaluated next cycle. O_bubble=0 and O_freeze_count increments.
- Issue (no hazard, no busy, no flush): the scoreboard shifts up, entry d+1 <= entry d and entry NUM_STAGES is dropped.
  - Entry 1 <= {I_dec_valid, I_dec_we, I_dec_isLoad, I_dec_regD}.
  - O_fwd_sel[s] <= lowest matching d, else 0.
- Bubble cycle: the scoreboard shifts with entry 1 <= invalid. O_fwd_sel <= 0. O_bubble_count increments, saturating at 2^32-1 (O_freeze_count saturates likewise).
- Flush: has priority over hazard and busy. The scoreboard shifts with entry 1 <= invalid and O_fwd_sel <= 0. O_stall=0, O_bubble=0, no counter changes.
- Distance beyond NUM_STAGES: the value is already in the regfile, so the select is 0.
- Latency: select valid exactly the cycle the consumer is in execute, one clock after issue. A hazard stall lasts LOAD_LAT-d+1 cycles.
- I_dec_valid=0: no hazard is raised. It issues as an invalid entry.

Test Plan:
- Back-to-back ALU dependency, defaults. Issue r3<=..., then r4<=r3+r5. Required: second instruction's src A select = 1, src B select = 0, no stall.
- Distance-2 dependency. Producer r7, unrelated instruction, then consumer reading r7 as store data (src 2). Required: select[2]=2. A third-distance consumer gets 0.
- Load-use, LOAD_LAT=1. Load r2, then add reading r2. Required: exactly 1 cycle of O_stall=O_bubble=1, then issue with select=2 and O_bubble_count=1.
  - Same with LOAD_LAT=2, NUM_STAGES=3: 2 bubble cycles, then select=3.
- Zero register. Producer writes r0, consumer reads r0. Required: select 0 with ZERO_REG=1, select 1 with ZERO_REG=0.
- Freeze. Hold I_ex_busy high for 3 cycles with a pending load-use. Required: O_bubble=0 throughout, O_fwd_sel unchanged, O_freeze_count=3. The bubble appears on the first non-busy cycle.
- Flush during hazard, then reset. Assert I_flush while a load-use hazard is present. Required: O_stall=0, the entry becomes invalid, the next decode reading the load reg gets select=2 with no bubble.
  - Assert I_rst mid-freeze. Required: both counters 0, all selects 0 after the edge.
